// File: rtl/frog_game_pkg.sv
// Shared definitions for the frog game controller.
//   state_t : game state encoding, also driven out on o_state
//   *_W     : widths of the lives / score / level / coordinate / frame counter fields
package frog_game_pkg;

  localparam int LIVES_W = 2;
  localparam int SCORE_W = 8;
  localparam int LEVEL_W = 3;
  localparam int COORD_W = 12;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

endpackage

// File: rtl/frog_game_ctrl_btn_sync_edge.sv
// btn_sync_edge: brings an asynchronous active-high button into the clock
// domain through two flops and emits a registered one-cycle pulse on its
// rising edge. Also used for the frog direction buttons.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_btn   : raw button level
//   o_pulse : one-cycle pulse, 3 clock edges after the button rises
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      // stage 0/1: metastability filter
      sync_p0 <= i_btn;
      sync_p1 <= sync_p0;
      // stage 2: edge detect against the previous synchronised level
      prev_p2 <= sync_p1;
      o_pulse <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: frame-level game sequencer for the frog/obstacle display.
// Accumulates frog/obstacle overlap over a frame, runs the
// IDLE/PLAY/HIT/WIN/OVER state machine and keeps lives, score and level.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_pix_stb      : pixel strobe (qualifies i_hit)
//   i_animate      : one-cycle end-of-frame pulse; all frame-level transitions happen here
//   i_hit          : frog and an obstacle overlap on the current pixel
//   i_frog_y1      : frog top edge
//   i_start_btn    : raw start button
//   o_respawn      : one-cycle frog respawn pulse
//   o_freeze       : hold frog and obstacles
//   o_flash        : blink flag while in HIT
//   o_lives, o_score, o_level, o_state : game status
// Build option: define FROG_BONUS_LIFE_EN to award a life (saturating at 3)
// on every 8th goal.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int LIVES      = 3,
  parameter int GOAL_Y     = 40,
  parameter int HIT_FRAMES = 60,
  parameter int WIN_FRAMES = 30,
  parameter int MAX_LEVEL  = 7
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_hit,
  input  logic [COORD_W-1:0] i_frog_y1,
  input  logic               i_start_btn,
  output logic               o_respawn,
  output logic               o_freeze,
  output logic               o_flash,
  output logic [LIVES_W-1:0] o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic [LEVEL_W-1:0] o_level,
  output logic [2:0]         o_state
);

  localparam logic [CNT_W-1:0]   HIT_LAST  = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0]   WIN_LAST  = CNT_W'(WIN_FRAMES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_inc_level(input logic [LEVEL_W-1:0] v);
    return (v >= LEVEL_MAX) ? LEVEL_MAX : v + LEVEL_W'(1);
  endfunction

`ifdef FROG_BONUS_LIFE_EN
  function automatic logic [LIVES_W-1:0] sat_inc_lives(input logic [LIVES_W-1:0] v);
    return (v == '1) ? v : v + LIVES_W'(1);
  endfunction
`endif

  logic start_evt;

  btn_sync_edge u_start_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_start_btn),
    .o_pulse (start_evt)
  );

  state_t               state_q, state_n;
  logic [LIVES_W-1:0]   lives_q, lives_n;
  logic [SCORE_W-1:0]   score_q, score_n;
  logic [LEVEL_W-1:0]   level_q, level_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 hit_seen_q, hit_seen_n;
  logic                 respawn_n, freeze_n, flash_n;
  logic                 hit_frame;
  logic                 goal;

  // A strobed hit on the animate cycle itself still belongs to the frame
  // that is ending, so it is folded in before the decision.
  assign hit_frame = hit_seen_q | (i_pix_stb & i_hit);
  assign goal      = (i_frog_y1 <= COORD_W'(GOAL_Y));

  always_comb begin
    state_n    = state_q;
    lives_n    = lives_q;
    score_n    = score_q;
    level_n    = level_q;
    cnt_n      = cnt_q;
    respawn_n  = 1'b0;
    hit_seen_n = i_animate ? 1'b0 : hit_frame;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_evt) begin
          lives_n   = LIVES_W'(LIVES);
          score_n   = '0;
          level_n   = '0;
          cnt_n     = '0;
          respawn_n = 1'b1;
          state_n   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (i_animate) begin
          if (hit_frame) begin
            // PLAY is only reachable with at least one life left
            lives_n = lives_q - LIVES_W'(1);
            cnt_n   = '0;
            state_n = ST_HIT;
          end else if (goal) begin
            score_n = sat_inc_score(score_q);
            level_n = sat_inc_level(level_q);
            cnt_n   = '0;
            state_n = ST_WIN;
`ifdef FROG_BONUS_LIFE_EN
            if ((score_n != score_q) && (score_n[2:0] == 3'd0))
              lives_n = sat_inc_lives(lives_q);
`endif
          end
        end
      end
      ST_HIT: begin
        if (i_animate) begin
          if (cnt_q == HIT_LAST) begin
            cnt_n = '0;
            if (lives_q == '0) begin
              state_n = ST_OVER;
            end else begin
              respawn_n = 1'b1;
              state_n   = ST_PLAY;
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WIN: begin
        if (i_animate) begin
          if (cnt_q == WIN_LAST) begin
            cnt_n     = '0;
            respawn_n = 1'b1;
            state_n   = ST_PLAY;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Outputs are computed from the next state so the registered copies line
    // up with the state they describe.
    freeze_n = (state_n != ST_PLAY);
    flash_n  = (state_n == ST_HIT) & cnt_n[3];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      lives_q    <= '0;
      score_q    <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      hit_seen_q <= 1'b0;
      o_respawn  <= 1'b0;
      o_freeze   <= 1'b1;
      o_flash    <= 1'b0;
    end else begin
      state_q    <= state_n;
      lives_q    <= lives_n;
      score_q    <= score_n;
      level_q    <= level_n;
      cnt_q      <= cnt_n;
      hit_seen_q <= hit_seen_n;
      o_respawn  <= respawn_n;
      o_freeze   <= freeze_n;
      o_flash    <= flash_n;
    end
  end

  assign o_lives = lives_q;
  assign o_score = score_q;
  assign o_level = level_q;
  assign o_state = state_q;

endmodule
